// File: rtl/instr_encoder.sv
// RV32I instruction encoder: validates a decoded request, encodes it into a 32-bit
// word and queues it in a 2-entry FIFO. Each emitted word carries a running word address.
// Rejected requests are still handshaken, but they only raise an error pulse and
// increment a saturating counter.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_kind,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic        in_funct7b5,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err_valid,
  output logic [1:0]  err_code,
  output logic [7:0]  err_count
);

  localparam logic [2:0] KindLw   = 3'd0;
  localparam logic [2:0] KindSw   = 3'd1;
  localparam logic [2:0] KindR    = 3'd2;
  localparam logic [2:0] KindBeq  = 3'd3;
  localparam logic [2:0] KindAddi = 3'd4;

  localparam logic [1:0] ErrNone    = 2'b00;
  localparam logic [1:0] ErrKind    = 2'b01;
  localparam logic [1:0] ErrRange   = 2'b10;
  localparam logic [1:0] ErrAligned = 2'b11;

  logic [1:0][31:0] mem_q, mem_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic [31:0]      addr_q, addr_d;
  logic             err_valid_q, err_valid_d;
  logic [1:0]       err_code_q, err_code_d;
  logic [7:0]       err_count_q, err_count_d;

  logic signed [31:0] imm_s;
  logic               imm12_ok;
  logic               immb_ok;
  logic [31:0]        enc_instr;
  logic [1:0]         enc_err;
  logic               accept;
  logic               push;
  logic               pop;

  assign imm_s    = in_imm;
  assign imm12_ok = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
  assign immb_ok  = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094);

  // Encode the request and classify it. The case order gives the error priority
  // kind > alignment > range.
  always_comb begin
    enc_instr = 32'h0;
    enc_err   = ErrNone;
    unique case (in_kind)
      KindLw: begin
        enc_instr = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
        if (!imm12_ok) enc_err = ErrRange;
      end
      KindSw: begin
        enc_instr = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
        if (!imm12_ok) enc_err = ErrRange;
      end
      KindR: begin
        enc_instr = {1'b0, in_funct7b5, 5'b0, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
      end
      KindBeq: begin
        enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000, in_imm[4:1],
                     in_imm[11], 7'b1100011};
        if (in_imm[0])     enc_err = ErrAligned;
        else if (!immb_ok) enc_err = ErrRange;
      end
      KindAddi: begin
        enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
        if (!imm12_ok) enc_err = ErrRange;
      end
      default: enc_err = ErrKind;
    endcase
  end

  // in_ready depends only on registered occupancy, so it has no path from out_ready.
  assign in_ready  = (count_q < 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign accept    = in_valid && in_ready;
  assign push      = accept && (enc_err == ErrNone);
  assign pop       = out_valid && out_ready;

  assign out_instr = out_valid ? mem_q[rd_ptr_q] : 32'h0;
  assign out_addr  = addr_q;
  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;
  assign err_count = err_count_q;

  // FIFO pointers and occupancy, address counter and error status next-state.
  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    addr_d      = addr_q;
    err_valid_d = 1'b0;
    err_code_d  = err_code_q;
    err_count_d = err_count_q;

    if (push) begin
      mem_d[wr_ptr_q] = enc_instr;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
      addr_d   = addr_q + 32'd4;
    end
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
    end

    if (accept && (enc_err != ErrNone)) begin
      err_valid_d = 1'b1;
      err_code_d  = enc_err;
      if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q       <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      addr_q      <= BASE_ADDR;
      err_valid_q <= 1'b0;
      err_code_q  <= 2'b00;
      err_count_q <= 8'd0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      addr_q      <= addr_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
      err_count_q <= err_count_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed testbench for instr_encoder with hand-computed expected encodings.
module tb_instr_encoder;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_kind;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic        in_funct7b5;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        err_valid;
  logic [1:0]  err_code;
  logic [7:0]  err_count;

  int n_checks;
  int n_fail;

  instr_encoder dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_kind    (in_kind),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_funct3  (in_funct3),
    .in_funct7b5(in_funct7b5),
    .in_imm     (in_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_addr   (out_addr),
    .err_valid  (err_valid),
    .err_code   (err_code),
    .err_count  (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] kind, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3, input logic f7b5,
                       input logic [31:0] imm);
    in_valid    = 1'b1;
    in_kind     = kind;
    in_rd       = rd;
    in_rs1      = rs1;
    in_rs2      = rs2;
    in_funct3   = f3;
    in_funct7b5 = f7b5;
    in_imm      = imm;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    out_ready = 1'b0;
    reset     = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    reset       = 1'b1;
    out_ready   = 1'b0;
    in_valid    = 1'b0;
    in_kind     = 3'd0;
    in_rd       = 5'd0;
    in_rs1      = 5'd0;
    in_rs2      = 5'd0;
    in_funct3   = 3'd0;
    in_funct7b5 = 1'b0;
    in_imm      = 32'h0;

    // Reset values, sampled before any clock edge.
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_out_addr", out_addr, 32'h0);
    check("rst_err_valid", 32'(err_valid), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    step();
    step();
    reset = 1'b0;

    // addi x1, x0, 5 with latency 1.
    drive(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5);
    step();
    idle();
    check("addi_valid", 32'(out_valid), 32'd1);
    check("addi_instr", out_instr, 32'h0050_0093);
    check("addi_addr", out_addr, 32'h0);

    // sw then beq, then drain.
    do_reset();
    drive(3'd1, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd8);
    step();
    drive(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'hFFFF_FFFC);
    step();
    idle();
    check("sw_instr", out_instr, 32'h0020_A423);
    check("sw_addr", out_addr, 32'h0);
    check("full_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    step();
    check("beq_instr", out_instr, 32'hFE20_8EE3);
    check("beq_addr", out_addr, 32'h4);
    step();
    out_ready = 1'b0;
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_addr", out_addr, 32'h8);

    // lw and R-type sub encodings.
    do_reset();
    out_ready = 1'b1;
    drive(3'd0, 5'd3, 5'd2, 5'd9, 3'd7, 1'b1, 32'hFFFF_FFFF);
    step();
    drive(3'd2, 5'd5, 5'd6, 5'd7, 3'd0, 1'b1, 32'h1234_5678);
    check("lw_instr", out_instr, 32'hFFF1_2183);
    step();
    idle();
    check("sub_instr", out_instr, 32'h4073_02B3);
    check("sub_addr", out_addr, 32'h4);
    step();
    out_ready = 1'b0;

    // Backpressure: three back-to-back requests with out_ready low.
    do_reset();
    drive(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd1);
    step();
    drive(3'd4, 5'd2, 5'd0, 5'd0, 3'd0, 1'b0, 32'd2);
    step();
    drive(3'd4, 5'd3, 5'd0, 5'd0, 3'd0, 1'b0, 32'd3);
    check("bp_ready_full", 32'(in_ready), 32'd0);
    step();
    check("bp_ready_held", 32'(in_ready), 32'd0);
    check("bp_head_a", out_instr, 32'h0010_0093);
    check("bp_addr_a", out_addr, 32'h0);
    out_ready = 1'b1;
    step();
    check("bp_head_b", out_instr, 32'h0020_0113);
    check("bp_addr_b", out_addr, 32'h4);
    check("bp_ready_free", 32'(in_ready), 32'd1);
    step();
    idle();
    check("bp_head_c", out_instr, 32'h0030_0193);
    check("bp_addr_c", out_addr, 32'h8);
    step();
    out_ready = 1'b0;
    check("bp_empty", 32'(out_valid), 32'd0);
    check("bp_addr_end", out_addr, 32'hC);

    // Rejects and their priority.
    do_reset();
    out_ready = 1'b1;
    drive(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd2048);
    step();
    check("err_range_valid", 32'(err_valid), 32'd1);
    check("err_range_code", 32'(err_code), 32'd2);
    drive(3'd7, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd0);
    step();
    check("err_kind_code", 32'(err_code), 32'd1);
    drive(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd3);
    step();
    idle();
    check("err_align_code", 32'(err_code), 32'd3);
    check("err_no_out", 32'(out_valid), 32'd0);
    step();
    check("err_pulse_end", 32'(err_valid), 32'd0);
    check("err_count3", 32'(err_count), 32'd3);
    drive(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd4097);
    step();
    check("err_prio_align", 32'(err_code), 32'd3);
    drive(3'd5, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd99999);
    step();
    check("err_prio_kind", 32'(err_code), 32'd1);
    drive(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd4096);
    step();
    check("err_beq_range", 32'(err_code), 32'd2);
    drive(3'd0, 5'd1, 5'd2, 5'd0, 3'd0, 1'b0, 32'hFFFF_F7FF);
    step();
    check("err_lw_low", 32'(err_code), 32'd2);
    check("err_count7", 32'(err_count), 32'd7);
    check("err_none_out", 32'(out_valid), 32'd0);
    // Boundary immediates that must be accepted.
    out_ready = 1'b0;
    drive(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'hFFFF_F800);
    step();
    drive(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd4094);
    check("bnd_addi_instr", out_instr, 32'h8000_0093);
    check("bnd_no_err", 32'(err_valid), 32'd0);
    out_ready = 1'b1;
    step();
    idle();
    check("bnd_beq_instr", out_instr, 32'h7E20_8FE3);
    check("bnd_count_same", 32'(err_count), 32'd7);
    step();
    out_ready = 1'b0;

    // Saturation of the reject counter.
    for (int i = 0; i < 260; i++) begin
      drive(3'd6, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd0);
      step();
    end
    idle();
    check("err_count_sat", 32'(err_count), 32'd255);

    // Asynchronous reset between edges discards queued words.
    do_reset();
    drive(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd1);
    step();
    drive(3'd4, 5'd2, 5'd0, 5'd0, 3'd0, 1'b0, 32'd2);
    step();
    idle();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("mid_addr_pre", out_addr, 32'h4);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    check("mid_rst_addr", out_addr, 32'h0);
    check("mid_rst_count", 32'(err_count), 32'd0);
    #1;
    reset = 1'b0;
    step();
    check("mid_post_empty", 32'(out_valid), 32'd0);
    drive(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5);
    step();
    idle();
    check("mid_post_instr", out_instr, 32'h0050_0093);
    check("mid_post_addr", out_addr, 32'h0);

    // Simultaneous push and pop at occupancy 1.
    do_reset();
    drive(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd100);
    step();
    check("pp_head0", out_instr, 32'h0640_0093);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'(i + 1));
      step();
      check("pp_instr", out_instr, (32'(i + 1) << 20) | 32'h93);
      check("pp_addr", out_addr, 32'(4 * (i + 1)));
      check("pp_ready", 32'(in_ready), 32'd1);
    end
    idle();
    step();
    out_ready = 1'b0;
    check("pp_empty", 32'(out_valid), 32'd0);
    check("pp_addr_end", out_addr, 32'd44);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
